des_iter_ctrl: RTL
==================

Name: des_iter_ctrl

Overview:
Iterative DES engine controller that reuses one instance of the existing combinational `round` block for all 16 Feistel rounds, one round per clock. It does the following:
- Captures a 64-bit block and a 64-bit key through a valid/ready handshake.
- Applies IP and derives each round key on the fly (PC-1, rotate, PC-2), forward for encrypt and reverse for decrypt.
- Applies the final 32-bit swap and FP.
- Presents the result on a valid/ready output port.

It sits between the bus-side block interface and the round datapath.

Parameters:
None. Round count is fixed at 16. Shift table S[1..16] = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 is a constant.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- in_valid_i  in  1  input block/key valid
- in_ready_o  out  1  controller can accept an input
- data_i  in  64  plaintext or ciphertext, bit 63 = DES bit 1
- key_i  in  64  DES key including parity bits; parity is ignored
- decrypt_i  in  1  0 = encrypt, 1 = decrypt; sampled at accept
- out_valid_o  out  1  result valid
- out_ready_i  in  1  consumer accepts result
- data_o  out  64  result block
- busy_o  out  1  high in ROUND or DONE
- round_cnt_o  out  4  current round index 0..15; 0 outside ROUND

Behaviour:
- Reset: when rst_n=0 at a clk edge, the following take effect on that edge and apply in any state, including mid-round and in DONE (all work in progress is discarded):
  - state=IDLE
  - in_ready_o=1, out_valid_o=0, busy_o=0, round_cnt_o=0, data_o=64'h0
  - internal block register, CD register and mode register = 0
- States:
  - IDLE: in_ready_o=1.
  - ROUND: in_ready_o=0.
  - DONE: in_ready_o=0, out_valid_o=1.
- Accept: on an edge where state=IDLE and in_valid_i=1:
  - blk <= IP(data_i)
  - CD <= PC1(key_i), 56 bits as C[27:0], D[27:0]
  - mode <= decrypt_i
  - cnt <= 0, state <= ROUND
  - in_valid_i is ignored in every state other than IDLE.
- ROUND, cycle k (cnt=k, 0..15):
  - Encrypt: CDk = C and D each rotated left by S[k+1].
  - Decrypt: CDk = CD unchanged when k=0; for k≥1, C and D each rotated right by S[17-k].
  - Round key = PC2(CDk) (48 bits), driven combinationally into `round` with round_64_i=blk.
  - On the edge: blk <= round_64_o, CD <= CDk, cnt <= k+1.
  - When k=15: state <= DONE, cnt <= 0, data_o <= FP({blk_next[31:0], blk_next[63:32]}), where blk_next is the round output.
  - round_cnt_o = cnt.
- Key-schedule consistency: after 16 encrypt rotations, CD equals PC1(key). The decrypt sequence therefore yields K16 down to K1.
- DONE:
  - out_valid_o=1 and data_o are held stable until an edge with out_ready_i=1.
  - On that edge: out_valid_o <= 0, state <= IDLE.
  - A new input is not accepted on that same edge; in_ready_o rises the following cycle.
- Latency: accept edge at cycle T → out_valid_o=1 after edge T+16 (16 ROUND cycles). Throughput is one block per 18 cycles minimum, with out_ready_i tied high.
- out_ready_i is ignored when out_valid_o=0.
- Input buses may change freely after the accept edge; the controller uses only captured state.
- Width rules: all rotations are modulo 28 per half. PC-1, PC-2, IP and FP are the FIPS 46-3 tables, with bit 1 = MSB.

Test Plan:
1. Encrypt known-answer test (KAT): key=133457799BBCDFF1, data=0123456789ABCDEF, decrypt=0 → data_o=85E813540F0AB405. out_valid_o rises exactly 16 cycles after the accept edge; round_cnt_o steps 0..15.
2. Decrypt KAT: same key, data=85E813540F0AB405, decrypt=1 → data_o=0123456789ABCDEF. Second vector: key=0E329232EA6D0D73 with data 8787878787878787 encrypts to 0000000000000000 and decrypts back.
3. Backpressure: hold out_ready_i=0 for 10 cycles after valid, toggling in_valid_i and data_i meanwhile. Required:
   - data_o stays stable and in_ready_o stays 0.
   - Result is accepted on the first out_ready_i=1 edge.
   - in_ready_o=1 on the next cycle.
4. Reset mid-operation: assert rst_n=0 at round 7, release, then run KAT 1. Required:
   - All outputs are 0 and in_ready_o=1 the cycle after reset.
   - The subsequent result is correct, with no residue from the aborted block.
5. Back-to-back: with out_ready_i=1 and in_valid_i held high, supply 3 random blocks/keys with mixed modes. Required:
   - Each accept is spaced 18 cycles apart.
   - Every result matches the software DES model.
6. Parity and mode independence: key 133457799BBCDFF1 versus 123456789ABCDEF0-style keys differing only in bits 8,16,…,64 give identical results. Changing decrypt_i after accept does not affect the result.

Source files
------------

// File: rtl/des_iter_ctrl_if.sv
// Handshake bundle between the bus-side block interface and the iterative DES controller.
// The slave modport is the controller; the master modport is whoever feeds blocks and drains results.
interface des_iter_ctrl_if;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [63:0] data_i;
    logic [63:0] key_i;
    logic        decrypt_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [63:0] data_o;

    modport slave (
        input  in_valid_i, data_i, key_i, decrypt_i, out_ready_i,
        output in_ready_o, out_valid_o, data_o
    );

    modport master (
        output in_valid_i, data_i, key_i, decrypt_i, out_ready_i,
        input  in_ready_o, out_valid_o, data_o
    );
endinterface

// File: rtl/des_iter_ctrl.sv
// Iterative DES controller: one Feistel round per clock through a single round datapath,
// round keys derived on the fly from the rotating CD register.
//
// state   | meaning
// S_IDLE  | waiting for a block/key, in_ready_o high
// S_ROUND | running Feistel round cnt_q (0..15)
// S_DONE  | result held on data_o until out_ready_i
module des_iter_ctrl (
    input  logic              clk,
    input  logic              rst_n,
    des_iter_ctrl_if.slave    bus,
    output logic              busy_o,
    output logic [3:0]        round_cnt_o
);

    typedef enum logic [1:0] {S_IDLE, S_ROUND, S_DONE} state_t;

    localparam int IP_T [64] = '{
        58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
        62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
        57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3,
        61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
    localparam int FP_T [64] = '{
        40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
        38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
        36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
        34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
    localparam int PC1_T [56] = '{
        57,49,41,33,25,17,9,  1,58,50,42,34,26,18,
        10,2,59,51,43,35,27,  19,11,3,60,52,44,36,
        63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
        14,6,61,53,45,37,29,  21,13,5,28,20,12,4};
    localparam int PC2_T [48] = '{
        14,17,11,24,1,5,   3,28,15,6,21,10,
        23,19,12,4,26,8,   16,7,27,20,13,2,
        41,52,31,37,47,55, 30,40,51,45,33,48,
        44,49,39,56,34,53, 46,42,50,36,29,32};
    localparam int E_T [48] = '{
        32,1,2,3,4,5,     4,5,6,7,8,9,
        8,9,10,11,12,13,  12,13,14,15,16,17,
        16,17,18,19,20,21, 20,21,22,23,24,25,
        24,25,26,27,28,29, 28,29,30,31,32,1};
    localparam int P_T [32] = '{
        16,7,20,21, 29,12,28,17, 1,15,23,26, 5,18,31,10,
        2,8,24,14,  32,27,3,9,   19,13,30,6, 22,11,4,25};
    // S1..S8 flattened as box*64 + row*16 + col.
    localparam int SBOX_T [512] = '{
        14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7,   0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
        4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0,   15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13,
        15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10,   3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
        0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15,   13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9,
        10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8,   13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
        13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7,   1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12,
        7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15,   13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
        10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4,   3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14,
        2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9,   14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
        4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14,   11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3,
        12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11,   10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
        9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6,   4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13,
        4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1,   13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
        1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2,   6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12,
        13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7,   1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
        7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8,   2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11};

    // Bit i set means shift-table entry S[i+1] is 2, otherwise 1.
    localparam logic [15:0] TWO_STEP = 16'b0111_1110_1111_1100;

    function automatic logic [63:0] ip_f(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - IP_T[i])];
        return y;
    endfunction

    function automatic logic [63:0] fp_f(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - FP_T[i])];
        return y;
    endfunction

    function automatic logic [55:0] pc1_f(input logic [63:0] x);
        logic [55:0] y;
        y = '0;
        for (int i = 0; i < 56; i++) y[6'(55 - i)] = x[6'(64 - PC1_T[i])];
        return y;
    endfunction

    function automatic logic [47:0] pc2_f(input logic [55:0] x);
        logic [47:0] y;
        y = '0;
        for (int i = 0; i < 48; i++) y[6'(47 - i)] = x[6'(56 - PC2_T[i])];
        return y;
    endfunction

    function automatic logic [47:0] e_f(input logic [31:0] x);
        logic [47:0] y;
        y = '0;
        for (int i = 0; i < 48; i++) y[6'(47 - i)] = x[5'(32 - E_T[i])];
        return y;
    endfunction

    function automatic logic [31:0] p_f(input logic [31:0] x);
        logic [31:0] y;
        y = '0;
        for (int i = 0; i < 32; i++) y[5'(31 - i)] = x[5'(32 - P_T[i])];
        return y;
    endfunction

    function automatic logic [31:0] sbox_f(input logic [47:0] x);
        logic [31:0] y;
        logic [5:0]  six;
        y = '0;
        for (int b = 0; b < 8; b++) begin
            six = x[6'(47 - 6 * b) -: 6];
            y[5'(31 - 4 * b) -: 4] = 4'(SBOX_T[{3'(b), six[5], six[0], six[4:1]}]);
        end
        return y;
    endfunction

    // The shared round datapath: L' = R, R' = L ^ f(R, K).
    function automatic logic [63:0] round_f(input logic [63:0] blk, input logic [47:0] k);
        return {blk[31:0], blk[63:32] ^ p_f(sbox_f(e_f(blk[31:0]) ^ k))};
    endfunction

    function automatic logic [27:0] rol_f(input logic [27:0] x, input logic two);
        return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

    function automatic logic [27:0] ror_f(input logic [27:0] x, input logic two);
        return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

    state_t      state_q, state_d;
    logic [63:0] blk_q, blk_d;
    logic [55:0] cd_q, cd_d;
    logic        mode_q, mode_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [63:0] data_q, data_d;

    logic [3:0]  dec_idx;
    logic [27:0] c_k, d_k;
    logic [63:0] blk_next;

    // Decrypt walks the shift table backwards: round k undoes S[17-k], i.e. entry 16-k.
    assign dec_idx = 4'd0 - cnt_q;

    always_comb begin
        c_k = cd_q[55:28];
        d_k = cd_q[27:0];
        if (!mode_q) begin
            c_k = rol_f(cd_q[55:28], TWO_STEP[cnt_q]);
            d_k = rol_f(cd_q[27:0],  TWO_STEP[cnt_q]);
        end else if (cnt_q != 4'd0) begin
            c_k = ror_f(cd_q[55:28], TWO_STEP[dec_idx]);
            d_k = ror_f(cd_q[27:0],  TWO_STEP[dec_idx]);
        end
    end

    assign blk_next = round_f(blk_q, pc2_f({c_k, d_k}));

    always_comb begin
        state_d = state_q;
        blk_d   = blk_q;
        cd_d    = cd_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid_i) begin
                    blk_d   = ip_f(bus.data_i);
                    cd_d    = pc1_f(bus.key_i);
                    mode_d  = bus.decrypt_i;
                    cnt_d   = 4'd0;
                    state_d = S_ROUND;
                end
            end
            S_ROUND: begin
                blk_d = blk_next;
                cd_d  = {c_k, d_k};
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    cnt_d   = 4'd0;
                    data_d  = fp_f({blk_next[31:0], blk_next[63:32]});
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            blk_q   <= '0;
            cd_q    <= '0;
            mode_q  <= 1'b0;
            cnt_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            blk_q   <= blk_d;
            cd_q    <= cd_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
        end
    end

    assign bus.in_ready_o  = (state_q == S_IDLE);
    assign bus.out_valid_o = (state_q == S_DONE);
    assign bus.data_o      = data_q;
    assign busy_o          = (state_q != S_IDLE);
    assign round_cnt_o     = cnt_q;

endmodule
